pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W-bit payload between two pipeline stages using a valid/ready handshake.
- A two-entry skid buffer gives full throughput while in_ready stays registered, which breaks the combinational ready path that hazard stalls otherwise create.
- Adds flush with optional payload clearing and a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_W, 128: payload width in bits (all stage fields concatenated by the instantiating stage).
- CLEAR_ON_FLUSH, 1: 1 = payload registers are zeroed on flush; 0 = payload is left stale and only valid is dropped.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous pipeline flush (branch mispredict or trap)
- in_valid  in  1  upstream presents a payload
- in_ready  out  1  stage can accept a payload; registered
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage holds a valid payload
- out_ready  in  1  downstream accepts the payload
- out_data  out  DATA_W  payload to downstream; registered
- occupancy  out  2  number of held entries (0..2)
- clr_stats  in  1  synchronous clear of stall_cycles
- stall_cycles  out  STALL_CNT_W  saturating count of back-pressure cycles

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=EMPTY, in_ready=1, out_valid=0, out_data=0, skid=0, occupancy=0, stall_cycles=0.
- Storage:
  - main register drives out_data.
  - skid register holds one overflow entry.
  - out_valid = (state != EMPTY); occupancy encodes the state: EMPTY=0, ONE=1, FULL=2.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_data is sampled only on in_fire.
  - While out_valid=1 and out_ready=0, out_data must not change.
- Latency: an accepted payload appears on out_data/out_valid in the next cycle when the stage was EMPTY, or when it was ONE with a simultaneous out_fire.
- State transitions (no flush):
  - EMPTY + in_fire -> ONE; main <= in_data.
  - ONE + in_fire + !out_fire -> FULL; skid <= in_data.
  - ONE + !in_fire + out_fire -> EMPTY.
  - ONE + in_fire + out_fire -> ONE; main <= in_data.
  - FULL + out_fire -> ONE; main <= skid. in_fire cannot occur in FULL because in_ready=0.
  - Any other combination holds the current state and data.
- in_ready is registered. Its next value is 0 only when the next state is FULL; otherwise 1.
- Flush (synchronous, highest priority over all handshake activity):
  - Next state is EMPTY; out_valid=0 and in_ready=1 next cycle.
  - A payload offered or accepted in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed downstream; the downstream stage does its own flushing.
  - If CLEAR_ON_FLUSH=1, main and skid are set to 0; otherwise they keep their values.
- stall_cycles:
  - Increments by 1 in every cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^STALL_CNT_W-1 with no wrap-around.
  - clr_stats takes priority over increment: the next value is 0.
  - flush does not clear the counter.
- A reset asserted mid-transfer aborts immediately to the reset values; no payload is preserved.
- No combinational path exists from out_ready to in_ready, or from in_data to out_data.

Decomposition:
- Shared pipeline package holds:
  - state encoding constants: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - the default widths.
- Stage payload packing and unpacking of pc, regs_data, imm, control and csr fields stays in the instantiating stage.
- One natural sub-module: sat_counter (parametrised width, enable, synchronous clear, saturate) for stall_cycles. It is reusable for other performance counters.

Test Plan:
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> out_data sequence 1..8, one cycle behind input; in_ready stays 1; occupancy=1 throughout.
- Back-pressure: push A, B with out_ready=0 -> occupancy 1 then 2; in_ready=0 after B; out_data holds A for 3 stall cycles and stall_cycles=3. Raise out_ready -> A then B delivered in order; in_ready=1 one cycle after A leaves.
- Flush while FULL: offer C in the flush cycle -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0 (CLEAR_ON_FLUSH=1). C never appears on the output.
- Flush with CLEAR_ON_FLUSH=0: same sequence -> out_valid=0 and out_data keeps its previous value A.
- Counter: STALL_CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles saturates at 15. Pulse clr_stats while the stall continues -> 0 the next cycle, then 1.
- Asynchronous reset while FULL -> outputs go to their reset values immediately without a clock edge. After release, the first payload passes through with 1-cycle latency.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the valid/ready pipeline stage: state encoding and default widths.
package pipe_skid_stage_pkg;

  localparam int DATA_W_DEF      = 128;
  localparam int STALL_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear wins over enable.
// Reusable for any performance counter that must never wrap.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline register with registered in_ready, flush and stall counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int STALL_CNT_W    = STALL_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  input  logic                   clr_stats,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr_i(clr_stats),
    .en_i (out_valid & ~out_ready),
    .cnt_o(stall_cycles)
  );

endmodule
